// File: rtl/iic_regs_pkg.sv
// Shared types, constants and helpers for the IIC slave register bank.
package iic_regs_pkg;

  localparam int IIC_REG_AW   = 6;
  localparam int IIC_MAX_REGS = 64;

  typedef logic [IIC_REG_AW-1:0] reg_ptr_t;

  // Write-side transaction phase.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PTR     = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } wr_state_e;

  // Pointer increment that wraps at the last implemented register rather
  // than at the natural 6-bit boundary.
  function automatic reg_ptr_t ptr_inc(input reg_ptr_t ptr, input int num_regs);
    if (ptr == reg_ptr_t'(num_regs - 1)) begin
      return '0;
    end
    return reg_ptr_t'(ptr + 1'b1);
  endfunction

endpackage

// File: rtl/iic_cont_write_regs_if.sv
// Byte-stream inputs and register-bank outputs of the IIC write register bank.
interface iic_cont_write_regs_if
  import iic_regs_pkg::*;
#(
  parameter int NUM_REGS = 48
);

  logic                  iStart;
  logic                  iStop;
  logic                  iByteValid;
  logic [7:0]            ivByte;
  logic                  iRdAck;
  logic [8*NUM_REGS-1:0] ovRegs;
  reg_ptr_t              ovPointer;
  logic                  oWrStrobe;
  reg_ptr_t              ovWrAddr;
  logic                  oAddrErr;
  logic                  oWrErr;
  logic                  oAccessDone;

  // Byte-stream source and register-bank consumer.
  modport master (
    output iStart, iStop, iByteValid, ivByte, iRdAck,
    input  ovRegs, ovPointer, oWrStrobe, ovWrAddr, oAddrErr, oWrErr, oAccessDone
  );

  // The register bank itself.
  modport slave (
    input  iStart, iStop, iByteValid, ivByte, iRdAck,
    output ovRegs, ovPointer, oWrStrobe, ovWrAddr, oAddrErr, oWrErr, oAccessDone
  );

endinterface

// File: rtl/iic_reg_ptr.sv
// Register pointer: load from the pointer byte, wrapped increment after a
// data byte or a completed host read, otherwise hold.
module iic_reg_ptr
  import iic_regs_pkg::*;
#(
  parameter int NUM_REGS = 48
) (
  input  logic     iClk,
  input  logic     iRst_n,
  input  logic     load_i,
  input  reg_ptr_t load_val_i,
  input  logic     inc_i,
  output reg_ptr_t ptr_o
);

  reg_ptr_t ptr_q;
  reg_ptr_t ptr_d;

  // Next pointer: load beats increment, otherwise hold.
  always_comb begin
    // NOTE: default assigned first so every path drives ptr_d; no latch.
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_inc(ptr_q, NUM_REGS);
    end
  end

  // Pointer register with synchronous reset to register 0.
  always_ff @(posedge iClk) begin
    // NOTE: non-blocking so every flop samples pre-edge values in parallel.
    if (!iRst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/iic_cont_write_regs.sv
// Write-side register bank of the IIC slave: pointer byte, then data bytes
// written at an auto-incrementing pointer that is exported for the read path.
module iic_cont_write_regs
  import iic_regs_pkg::*;
#(
  parameter int                    NUM_REGS = 48,
  parameter logic [NUM_REGS-1:0]   WR_MASK  = {NUM_REGS{1'b1}},
  parameter logic [8*NUM_REGS-1:0] RST_VALS = '0
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  iic_cont_write_regs_if.slave bus
);

  wr_state_e  state_q, state_d;
  logic [7:0] regs_q [NUM_REGS];
  reg_ptr_t   ptr;
  logic       ptr_load, ptr_inc_en;
  logic       wr_en_d, wr_err_d, addr_err_d;
  logic       ptr_in_range, ptr_writable;
  logic       wr_strobe_q, wr_err_q, addr_err_q;
  reg_ptr_t   wr_addr_q;
  logic [1:0] acc_q;

  iic_reg_ptr #(.NUM_REGS(NUM_REGS)) u_ptr (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .load_i     (ptr_load),
    .load_val_i (bus.ivByte[IIC_REG_AW-1:0]),
    .inc_i      (ptr_inc_en),
    .ptr_o      (ptr)
  );

  // Next state and per-byte actions; a start drops any coincident byte.
  always_comb begin
    state_d      = state_q;
    ptr_load     = 1'b0;
    ptr_inc_en   = 1'b0;
    wr_en_d      = 1'b0;
    wr_err_d     = 1'b0;
    addr_err_d   = 1'b0;
    ptr_in_range = (bus.ivByte < 8'(NUM_REGS));
    ptr_writable = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr == reg_ptr_t'(i)) ptr_writable = WR_MASK[i];
    end

    if (bus.iStart) begin
      state_d = PTR;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.iRdAck && !bus.iByteValid) ptr_inc_en = 1'b1;
        end
        PTR: begin
          if (bus.iByteValid) begin
            if (ptr_in_range) begin
              ptr_load = 1'b1;
              state_d  = DATA;
            end else begin
              addr_err_d = 1'b1;
              state_d    = DISCARD;
            end
          end
        end
        DATA: begin
          if (bus.iByteValid) begin
            ptr_inc_en = 1'b1;
            if (ptr_writable) wr_en_d  = 1'b1;
            else              wr_err_d = 1'b1;
          end
        end
        DISCARD: begin
          if (bus.iByteValid) wr_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      // A stop still lets a coincident byte be processed above.
      if (bus.iStop) state_d = IDLE;
    end
  end

  // State, registered pulses and the two-stage access-done pipeline.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      wr_strobe_q <= 1'b0;
      wr_err_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_addr_q   <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_strobe_q <= wr_en_d;
      wr_err_q    <= wr_err_d;
      addr_err_q  <= addr_err_d;
      wr_addr_q   <= wr_en_d ? ptr : '0;
      acc_q       <= {acc_q[0], bus.iByteValid};
    end
  end

  // Register array, written at the current pointer.
  always_ff @(posedge iClk) begin
    // NOTE: this is a flop bank with defined power-on values, so it is reset;
    // a RAM-style array would normally be left unreset.
    if (!iRst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VALS[8*i +: 8];
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_d && ptr == reg_ptr_t'(i)) regs_q[i] <= bus.ivByte;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign bus.ovRegs[8*g +: 8] = regs_q[g];
  end

  assign bus.ovPointer   = ptr;
  assign bus.oWrStrobe   = wr_strobe_q;
  assign bus.ovWrAddr    = wr_addr_q;
  assign bus.oAddrErr    = addr_err_q;
  assign bus.oWrErr      = wr_err_q;
  assign bus.oAccessDone = acc_q[1];

endmodule

// File: tb/tb_iic_cont_write_regs.sv
// Self-checking bench: directed IIC write sequences against a behavioural
// model of the register bank, compared on every cycle.
module tb_iic_cont_write_regs;

  localparam int NUM_REGS = 48;
  localparam int W        = 8 * NUM_REGS;
  localparam logic [NUM_REGS-1:0] WR_MASK = 48'hFFFF_FFFF_FFF7;

  function automatic logic [W-1:0] mk_rst_vals();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = 8'(i * 7 + 3);
    return v;
  endfunction

  localparam logic [W-1:0] RST_VALS = mk_rst_vals();

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  iic_cont_write_regs_if #(.NUM_REGS(NUM_REGS)) bus ();

  iic_cont_write_regs #(
    .NUM_REGS (NUM_REGS),
    .WR_MASK  (WR_MASK),
    .RST_VALS (RST_VALS)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_PTR, M_DATA, M_DISCARD} mode_e;
  logic [7:0] m_regs [NUM_REGS];
  int         m_ptr = 0;
  mode_e      m_mode = M_IDLE;
  bit         m_strobe, m_addr_err, m_wr_err;
  int         m_wr_addr;
  bit [1:0]   m_acc;
  bit         m_ready = 0;

  always @(posedge iClk) begin
    m_strobe   = 0;
    m_addr_err = 0;
    m_wr_err   = 0;
    if (!iRst_n) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = RST_VALS[8*i +: 8];
      m_ptr   = 0;
      m_mode  = M_IDLE;
      m_acc   = 0;
      m_ready = 1;
    end else begin
      m_acc = {m_acc[0], bus.iByteValid};
      if (bus.iStart) begin
        m_mode = M_PTR;
      end else begin
        if (bus.iByteValid) begin
          case (m_mode)
            M_PTR:
              if (int'(bus.ivByte) < NUM_REGS) begin
                m_ptr  = int'(bus.ivByte);
                m_mode = M_DATA;
              end else begin
                m_addr_err = 1;
                m_mode     = M_DISCARD;
              end
            M_DATA: begin
              if (WR_MASK[m_ptr]) begin
                m_regs[m_ptr] = bus.ivByte;
                m_strobe      = 1;
                m_wr_addr     = m_ptr;
              end else begin
                m_wr_err = 1;
              end
              m_ptr = (m_ptr + 1) % NUM_REGS;
            end
            M_DISCARD: m_wr_err = 1;
            default: ;
          endcase
        end else if (bus.iRdAck && m_mode == M_IDLE) begin
          m_ptr = (m_ptr + 1) % NUM_REGS;
        end
        if (bus.iStop) m_mode = M_IDLE;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [W-1:0] exp_regs;
  logic [5:0]   strobe_log [$];
  int           wr_err_cnt   = 0;
  int           addr_err_cnt = 0;

  always @(negedge iClk) begin
    if (m_ready) begin
      for (int i = 0; i < NUM_REGS; i++) exp_regs[8*i +: 8] = m_regs[i];
      check("regs",        bus.ovRegs,              exp_regs);
      check("pointer",     W'(bus.ovPointer),       W'(m_ptr));
      check("wr_strobe",   W'(bus.oWrStrobe),       W'(m_strobe));
      check("addr_err",    W'(bus.oAddrErr),        W'(m_addr_err));
      check("wr_err",      W'(bus.oWrErr),          W'(m_wr_err));
      check("access_done", W'(bus.oAccessDone),     W'(m_acc[1]));
      if (m_strobe) check("wr_addr", W'(bus.ovWrAddr), W'(m_wr_addr));
      if (bus.oWrStrobe === 1'b1) strobe_log.push_back(bus.ovWrAddr);
      if (bus.oWrErr === 1'b1)    wr_err_cnt++;
      if (bus.oAddrErr === 1'b1)  addr_err_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit s, input bit p, input bit v, input logic [7:0] b, input bit r);
    bus.iStart     = s;
    bus.iStop      = p;
    bus.iByteValid = v;
    bus.ivByte     = b;
    bus.iRdAck     = r;
    @(posedge iClk);
    #1;
    bus.iStart     = 1'b0;
    bus.iStop      = 1'b0;
    bus.iByteValid = 1'b0;
    bus.ivByte     = 8'h00;
    bus.iRdAck     = 1'b0;
  endtask

  task automatic start();                    drive(1, 0, 0, 8'h00, 0); endtask
  task automatic stop();                     drive(0, 1, 0, 8'h00, 0); endtask
  task automatic rdack();                    drive(0, 0, 0, 8'h00, 1); endtask
  task automatic wbyte(input logic [7:0] b); drive(0, 0, 1, b, 0);     endtask

  function automatic logic [W-1:0] dreg(input int n);
    return W'(bus.ovRegs[8*n +: 8]);
  endfunction

  function automatic logic [W-1:0] strobe_pair();
    if (strobe_log.size() != 2) return '1;
    return W'({strobe_log[0], strobe_log[1]});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.iStart = 1'b0; bus.iStop = 1'b0; bus.iByteValid = 1'b0;
    bus.ivByte = 8'h00; bus.iRdAck = 1'b0;
    iRst_n = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    iRst_n = 1'b1;

    // Reset state
    check("rst_ptr",    W'(bus.ovPointer), W'(6'd0));
    check("rst_regs",   bus.ovRegs,        RST_VALS);
    check("rst_reg3",   dreg(3),           W'(8'h18));
    check("rst_strobe", W'(bus.oWrStrobe), W'(1'b0));

    // Basic write: ptr 5, data AA BB
    strobe_log.delete();
    start(); wbyte(8'h05); wbyte(8'hAA); wbyte(8'hBB); stop();
    check("w1_reg5",    dreg(5),           W'(8'hAA));
    check("w1_reg6",    dreg(6),           W'(8'hBB));
    check("w1_ptr",     W'(bus.ovPointer), W'(6'h07));
    check("w1_m_reg5",  W'(m_regs[5]),     W'(8'hAA));
    check("w1_strobes", strobe_pair(),     W'({6'd5, 6'd6}));

    // Wrap at NUM_REGS-1
    start(); wbyte(8'h2F); wbyte(8'h11); wbyte(8'h22); stop();
    check("wrap_reg47", dreg(47),          W'(8'h11));
    check("wrap_reg0",  dreg(0),           W'(8'h22));
    check("wrap_ptr",   W'(bus.ovPointer), W'(6'h01));

    // Read-only register 3
    wr_err_cnt = 0;
    start(); wbyte(8'h03); wbyte(8'h55); wbyte(8'h66); stop();
    check("ro_reg3",   dreg(3),           W'(8'h18));
    check("ro_reg4",   dreg(4),           W'(8'h66));
    check("ro_ptr",    W'(bus.ovPointer), W'(6'h05));
    check("ro_wr_err", W'(wr_err_cnt),    W'(1));

    // Bad pointer then discarded data
    wr_err_cnt = 0; addr_err_cnt = 0; strobe_log.delete();
    start(); wbyte(8'h30); wbyte(8'h77);
    check("bad_addr_err", W'(addr_err_cnt),  W'(1));
    check("bad_ptr",      W'(bus.ovPointer), W'(6'h05));
    stop();
    check("bad_wr_err",   W'(wr_err_cnt),        W'(1));
    check("bad_nowrite",  W'(strobe_log.size()), W'(0));

    // Pointer handoff to the read path
    start(); wbyte(8'h10); stop();
    repeat (3) rdack();
    check("hand_ptr_13", W'(bus.ovPointer), W'(6'h13));
    start(); wbyte(8'h2E); stop();
    repeat (3) rdack();
    check("hand_ptr_wrap", W'(bus.ovPointer), W'(6'h01));
    check("hand_m_ptr",    W'(m_ptr),         W'(1));

    // Start with byte: byte dropped, next byte is the pointer
    drive(1, 0, 1, 8'h08, 0);
    wbyte(8'h09);
    check("col_start_ptr", W'(bus.ovPointer), W'(6'h09));
    wbyte(8'h3C);
    check("col_reg9", dreg(9),           W'(8'h3C));
    check("col_reg8", dreg(8),           W'(8'h3B));
    // Stop with byte: byte written, then idle
    drive(0, 1, 1, 8'h44, 0);
    check("col_stop_reg10", dreg(10),          W'(8'h44));
    check("col_stop_ptr",   W'(bus.ovPointer), W'(6'h0B));
    wbyte(8'h99);
    check("idle_byte_reg11", dreg(11), W'(8'h50));
    // Read ack with byte in idle: ignored
    drive(0, 0, 1, 8'h12, 1);
    check("col_rdack_ptr", W'(bus.ovPointer), W'(6'h0B));
    // Read ack outside idle: ignored
    start(); rdack();
    check("rdack_busy_ptr", W'(bus.ovPointer), W'(6'h0B));
    // Start with stop: start wins
    drive(1, 1, 0, 8'h00, 0);
    wbyte(8'h02);
    check("col_ss_ptr", W'(bus.ovPointer), W'(6'h02));
    stop();

    // Access-done pipeline, in idle
    wbyte(8'h7E);
    check("acc_d1", W'(bus.oAccessDone), W'(1'b0));
    @(posedge iClk); #1;
    check("acc_d2", W'(bus.oAccessDone), W'(1'b1));
    @(posedge iClk); #1;
    check("acc_d3", W'(bus.oAccessDone), W'(1'b0));

    // Reset during DATA with a byte in flight
    start(); wbyte(8'h20); wbyte(8'hEE);
    check("pre_rst_reg32", dreg(32), W'(8'hEE));
    bus.iByteValid = 1'b1; bus.ivByte = 8'h5A;
    iRst_n = 1'b0;
    @(posedge iClk); #1;
    bus.iByteValid = 1'b0; bus.ivByte = 8'h00;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    check("mid_rst_reg32", dreg(32),          W'(8'hE3));
    check("mid_rst_regs",  bus.ovRegs,        RST_VALS);
    check("mid_rst_ptr",   W'(bus.ovPointer), W'(6'd0));
    wbyte(8'h04);
    check("mid_rst_idle", W'(bus.ovPointer), W'(6'd0));

    repeat (3) @(posedge iClk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
